// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction ROM read bus between fetch stage and ROM
interface fetch_unit_if #(
    parameter int WIDTH          = 32,
    parameter int ROM_ADDR_WIDTH = 10
);
    logic                      rd_en;
    logic [ROM_ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]          rd_data;

    modport master (output rd_en, output addr, input  rd_data);
    modport slave  (input  rd_en, input  addr, output rd_data);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC to ROM word address, fault flags, fetch counter
module fetch_unit #(
    parameter int               WIDTH          = 32,
    parameter int               ROM_ADDR_WIDTH = 10,
    parameter logic [WIDTH-1:0] ROM_BASE       = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   pc,
    input  logic               stall,
    input  logic               fault_clr,
    fetch_unit_if.master       ibus,
    output logic [WIDTH-1:0]   inst,
    output logic               inst_misaligned,
    output logic               inst_access_fault,
    output logic [1:0]         fault_sticky,
    output logic [WIDTH-1:0]   fetch_count
);

    // Addressing drops the byte offset and anything above the ROM window;
    // out-of-window PCs alias onto the ROM and are flagged, not masked.
    assign ibus.addr         = pc[ROM_ADDR_WIDTH+1:2];
    assign ibus.rd_en        = rst_n & ~stall;
    assign inst              = ibus.rd_data;
    assign inst_misaligned   = (pc[1:0] != 2'b00);
    assign inst_access_fault = (pc[WIDTH-1:ROM_ADDR_WIDTH+2] != ROM_BASE[WIDTH-1:ROM_ADDR_WIDTH+2]);

    logic [1:0] fault_now;
    assign fault_now = {inst_access_fault, inst_misaligned} & {2{~stall}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= '0;
            fault_sticky <= 2'b00;
        end else begin
            if (!stall) begin
                fetch_count <= fetch_count + 1'b1;
            end
            // A fault seen this cycle wins over a simultaneous clear.
            fault_sticky <= (fault_sticky & {2{~fault_clr}}) | fault_now;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        fault_clr;
    logic [31:0] inst;
    logic        inst_misaligned;
    logic        inst_access_fault;
    logic [1:0]  fault_sticky;
    logic [31:0] fetch_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned m_count  = 0;
    logic [1:0]  m_sticky = 2'b00;

    fetch_unit_if #(.WIDTH(32), .ROM_ADDR_WIDTH(10)) ibus ();

    fetch_unit #(.WIDTH(32), .ROM_ADDR_WIDTH(10), .ROM_BASE(32'h0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc                (pc),
        .stall             (stall),
        .fault_clr         (fault_clr),
        .ibus              (ibus),
        .inst              (inst),
        .inst_misaligned   (inst_misaligned),
        .inst_access_fault (inst_access_fault),
        .fault_sticky      (fault_sticky),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One fetch cycle: drive, check the combinational view, clock, check state.
    task automatic cycle(input logic [31:0] p, input logic [31:0] d, input logic s, input logic c);
        logic mis, acc;
        pc = p; ibus.rd_data = d; stall = s; fault_clr = c;
        #1;
        mis = (p % 4) != 0;
        acc = (p / 4096) != 0;
        check("ibus_addr", 32'(ibus.addr), (p / 4) % 1024);
        check("inst", inst, d);
        check("misaligned", 32'(inst_misaligned), 32'(mis));
        check("access_fault", 32'(inst_access_fault), 32'(acc));
        check("rd_en", 32'(ibus.rd_en), 32'(!s));
        if (!s) m_count++;
        if (!s && mis)  m_sticky[0] = 1'b1; else if (c) m_sticky[0] = 1'b0;
        if (!s && acc)  m_sticky[1] = 1'b1; else if (c) m_sticky[1] = 1'b0;
        @(posedge clk);
        #1;
        check("fetch_count", fetch_count, m_count);
        check("fault_sticky", 32'(fault_sticky), 32'(m_sticky));
    endtask

    initial begin
        logic [31:0] p;
        rst_n = 1'b0; pc = '0; stall = 1'b0; fault_clr = 1'b0; ibus.rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", fetch_count, 32'd0);
        check("reset_sticky", 32'(fault_sticky), 32'd0);
        check("reset_rd_en", 32'(ibus.rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_count = 1;
        check("first_edge_count", fetch_count, 32'd1);

        // Counting with stall: 5 active edges then 3 stalled ones.
        for (int i = 0; i < 5; i++) cycle(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("count_after_stall", fetch_count, 32'd6);

        // ROM window boundaries.
        cycle(32'h0000_0FFC, 32'h1234_5678, 1'b0, 1'b0);
        cycle(32'h0000_1000, 32'h8765_4321, 1'b0, 1'b0);
        cycle(32'h0000_0000, 32'h0, 1'b0, 1'b1);

        // Misaligned sets bit0, aligned fetch with clear drops it.
        cycle(32'h0000_0006, 32'hA5A5_A5A5, 1'b0, 1'b0);
        cycle(32'h0000_0008, 32'h5A5A_5A5A, 1'b0, 1'b1);
        // Stalled fault is not latched; set beats clear.
        cycle(32'h0000_0003, 32'h0, 1'b1, 1'b0);
        cycle(32'h0000_0003, 32'h0, 1'b0, 1'b1);
        cycle(32'h0000_0000, 32'h0, 1'b1, 1'b1);

        // Aligned random fetches, upper bits sometimes nonzero.
        for (int i = 0; i < 128; i++) begin
            p = {($urandom_range(1) != 0) ? 20'($urandom) : 20'h0, 10'($urandom), 2'b00};
            cycle(p, ~p, $urandom_range(3) == 0, $urandom_range(7) == 0);
        end
        // Fully random PCs to exercise sticky bits.
        for (int i = 0; i < 64; i++) begin
            p = $urandom;
            if ($urandom_range(1) != 0) p = p & 32'h0000_0FFF;
            cycle(p, $urandom, $urandom_range(3) == 0, $urandom_range(3) == 0);
        end

        // Asynchronous reset mid-cycle.
        cycle(32'h2000_0001, 32'h0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        m_count = 0; m_sticky = 2'b00;
        check("async_count", fetch_count, 32'd0);
        check("async_sticky", 32'(fault_sticky), 32'd0);
        check("async_rd_en", 32'(ibus.rd_en), 32'd0);
        stall = 1'b1; fault_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_hold", fetch_count, 32'd0);
        for (int i = 0; i < 4; i++) cycle(32'(i * 4), 32'(i), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the core.
- Converts the byte-address program counter into a word address for the instruction ROM bus and returns the ROM word as the current instruction in the same cycle.
- Flags misaligned and out-of-ROM fetches.
- Keeps a small clocked status block: a fetch counter and a sticky fault register.

Parameters:
- WIDTH, 32, datapath and PC width in bits.
- ROM_ADDR_WIDTH, 10, word-address width of the instruction ROM (ROM holds 2^ROM_ADDR_WIDTH words).
- ROM_BASE, 0, byte base address of the ROM; bits [ROM_ADDR_WIDTH+1:0] must be zero.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pc, input, WIDTH, byte address of the instruction to fetch.
- stall, input, 1, pipeline stall; suppresses ibus_rd_en and counting.
- fault_clr, input, 1, clears the sticky fault register.
- ibus_rd_en, output, 1, ROM read enable.
- ibus_addr, output, ROM_ADDR_WIDTH, ROM word address.
- ibus_rd_data, input, WIDTH, ROM read data, combinationally valid for ibus_addr.
- inst, output, WIDTH, fetched instruction.
- inst_misaligned, output, 1, pc[1:0] != 0.
- inst_access_fault, output, 1, pc outside the ROM window.
- fault_sticky, output, 2, latched {access_fault, misaligned}.
- fetch_count, output, WIDTH, number of cycles with ibus_rd_en high since reset.

Behaviour:
- Datapath is purely combinational, zero latency, independent of clk/rst_n/stall:
  - ibus_addr = pc[ROM_ADDR_WIDTH+1:2]. pc[1:0] and pc above ROM_ADDR_WIDTH+1 are ignored for addressing.
  - inst = ibus_rd_data, unmodified. Faults never mask or alter inst; the downstream stage decides.
- ibus_rd_en = rst_n & ~stall.
- inst_misaligned = (pc[1:0] != 0), combinational.
- inst_access_fault = (pc[WIDTH-1:ROM_ADDR_WIDTH+2] != ROM_BASE[WIDTH-1:ROM_ADDR_WIDTH+2]), combinational. With ROM_BASE = 0, any nonzero upper bit flags a fault while ibus_addr still wraps onto the low bits.
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert is the integrator's responsibility):
  - fetch_count = 0.
  - fault_sticky = 0.
  - Outputs revert immediately.
- fetch_count:
  - Increments by 1 on each rising edge where ibus_rd_en = 1.
  - Wraps from all-ones to 0.
  - Holds while stall = 1.
- fault_sticky, on each rising edge:
  - Bit0 <= (bit0 | inst_misaligned) & ~fault_clr_only. Bit1 is the same with inst_access_fault.
  - Set has priority over clear: if fault_clr = 1 and a fault is present that cycle, the bit ends set.
  - When stall = 1, new faults are not latched, but fault_clr still clears.
- No internal storage of inst; a one-cycle pipeline register, if needed, belongs to the decode stage.

Test Plan:
- pc = 0x0000_0000, ibus_rd_data = 0xFFFF_FFFF -> ibus_addr = 0, inst = 0xFFFF_FFFF, no faults, same cycle.
- 128 random cycles:
  - pc[11:2] random, pc[31:12] zero or random, pc[1:0] = 0, ibus_rd_data = ~pc.
  - Required: ibus_addr = pc[11:2] and inst = ~pc every cycle.
  - Required: inst_access_fault high exactly when pc[31:12] != 0.
- pc = 0x0000_0FFC -> ibus_addr = 0x3FF. pc = 0x0000_1000 -> ibus_addr = 0x000, inst_access_fault = 1.
- pc = 0x0000_0006:
  - inst_misaligned = 1, ibus_addr = 1.
  - Next edge fault_sticky = 2'b01.
  - fault_clr with aligned pc next cycle -> 2'b00.
- Reset released, stall = 0 for 5 edges, stall = 1 for 3 edges -> fetch_count = 5, ibus_rd_en = 0 during stall.
- Assert rst_n = 0 mid-cycle -> fetch_count and fault_sticky go 0 immediately, without waiting for an edge.
